// File: rtl/fetch_controller_if.sv
// Handshake and memory bus between the fetch controller, instruction memory and the IF/ID stage.
interface fetch_controller_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      imem_address;
    logic [31:0]      imem_instruction;
    logic             redirect_valid;
    logic [31:0]      redirect_target;
    logic             out_ready;
    logic             out_valid;
    logic [31:0]      out_instruction;
    logic [31:0]      out_pc;
    logic [31:0]      out_pc_plus4;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        output imem_address,
        input  imem_instruction,
        input  redirect_valid,
        input  redirect_target,
        input  out_ready,
        output out_valid,
        output out_instruction,
        output out_pc,
        output out_pc_plus4,
        output halted,
        output fault,
        output fetch_count
    );

    modport slave (
        input  imem_address,
        output imem_instruction,
        output redirect_valid,
        output redirect_target,
        output out_ready,
        input  out_valid,
        input  out_instruction,
        input  out_pc,
        input  out_pc_plus4,
        input  halted,
        input  fault,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_controller.sv
// Owns the PC, addresses instruction memory and registers each fetched word into a valid/ready stage,
// handling decode stalls, redirects with flush, end-of-program halt and misaligned-target fault.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 103,
    parameter int          CNT_W     = 16
) (
    input logic             clk,
    input logic             rst,
    fetch_controller_if.master bus
);
    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};
    localparam logic [29:0] END_WORD = 30'(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT,
        FAULT
    } state_t;

    state_t           state;
    logic [31:0]      pc;
    logic             valid;
    logic [31:0]      instr;
    logic [31:0]      opc;
    logic [31:0]      opc_plus4;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] count;

    logic slot_free;
    logic target_aligned;
    logic target_in_range;
    logic pc_past_end;

    assign slot_free       = !valid || bus.out_ready;
    assign target_aligned  = (bus.redirect_target[1:0] == 2'b00);
    assign target_in_range = (bus.redirect_target[31:2] < END_WORD);
    assign pc_past_end     = (pc[31:2] >= END_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= START_PC;
            valid     <= 1'b0;
            instr     <= 32'h0;
            opc       <= 32'h0;
            opc_plus4 <= 32'h4;
            halted    <= 1'b0;
            fault     <= 1'b0;
            count     <= '0;
        end else begin
            // A handshake counts even when a redirect flushes the slot in the same cycle.
            if (valid && bus.out_ready && (count != '1)) begin
                count <= count + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    state <= FETCH;
                end

                FETCH: begin
                    if (bus.redirect_valid) begin
                        valid <= 1'b0;
                        if (!target_aligned) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            pc <= bus.redirect_target;
                        end
                    end else if (slot_free) begin
                        if (pc_past_end) begin
                            state  <= HALT;
                            halted <= 1'b1;
                            valid  <= 1'b0;
                        end else begin
                            instr     <= bus.imem_instruction;
                            opc       <= pc;
                            opc_plus4 <= pc + 32'd4;
                            valid     <= 1'b1;
                            pc        <= pc + 32'd4;
                        end
                    end
                end

                // Only a redirect back into the program can restart fetching.
                HALT: begin
                    if (bus.redirect_valid) begin
                        if (!target_aligned) begin
                            state  <= FAULT;
                            fault  <= 1'b1;
                            halted <= 1'b0;
                        end else if (target_in_range) begin
                            state  <= FETCH;
                            halted <= 1'b0;
                            pc     <= bus.redirect_target;
                        end
                    end
                end

                FAULT: begin
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.imem_address    = pc;
    assign bus.out_valid       = valid;
    assign bus.out_instruction = instr;
    assign bus.out_pc          = opc;
    assign bus.out_pc_plus4    = opc_plus4;
    assign bus.halted          = halted;
    assign bus.fault           = fault;
    assign bus.fetch_count     = count;
endmodule

// File: tb/tb_fetch_controller.sv
// Directed-vector bench for fetch_controller: a stimulus table for start-up, stall, redirect and reset,
// followed by hand-written sequences for running to the end of the program and for the fault state.
module tb_fetch_controller;
    logic clk;
    logic rst;

    fetch_controller_if #(.CNT_W(16)) bus ();

    fetch_controller #(
        .RESET_PC (32'h0000_0000),
        .MEM_WORDS(103),
        .CNT_W    (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    typedef struct {
        logic        rst;
        logic        rdv;
        logic [31:0] tgt;
        logic        rdy;
        logic        exp_valid;
        logic        chk_data;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_plus4;
        logic [31:0] exp_addr;
        logic        exp_halted;
        logic        exp_fault;
        logic [15:0] exp_count;
    } vec_t;

    int vectors_applied = 0;
    int miscompares     = 0;

    function automatic logic [31:0] mem_word(input logic [29:0] idx);
        return 32'hA500_0000 ^ {idx[15:0], ~idx[15:0]};
    endfunction

    // Instruction memory is a combinational read of the word addressed by the controller.
    assign bus.imem_instruction = mem_word(bus.imem_address[31:2]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] t, input logic rd,
                                input logic ev, input logic cd, input logic [31:0] epc,
                                input logic [31:0] ea, input logic eh, input logic ef,
                                input logic [15:0] ec);
        vec_t v;
        v.rst        = r;
        v.rdv        = rv;
        v.tgt        = t;
        v.rdy        = rd;
        v.exp_valid  = ev;
        v.chk_data   = cd;
        v.exp_pc     = epc;
        v.exp_instr  = ev ? mem_word(epc[31:2]) : 32'h0;
        v.exp_plus4  = epc + 32'd4;
        v.exp_addr   = ea;
        v.exp_halted = eh;
        v.exp_fault  = ef;
        v.exp_count  = ec;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst                 = v.rst;
        bus.redirect_valid  = v.rdv;
        bus.redirect_target = v.tgt;
        bus.out_ready       = v.rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        logic ok;
        ok = (bus.out_valid == v.exp_valid) && (bus.imem_address == v.exp_addr) &&
             (bus.halted == v.exp_halted) && (bus.fault == v.exp_fault) &&
             (bus.fetch_count == v.exp_count);
        if (v.chk_data) begin
            ok = ok && (bus.out_pc == v.exp_pc) && (bus.out_instruction == v.exp_instr) &&
                 (bus.out_pc_plus4 == v.exp_plus4);
        end
        vectors_applied++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL %s: got valid=%0b pc=%h instr=%h plus4=%h addr=%h halted=%0b fault=%0b count=%0d; expected valid=%0b pc=%h instr=%h plus4=%h addr=%h halted=%0b fault=%0b count=%0d (data checked=%0b)",
                     name, bus.out_valid, bus.out_pc, bus.out_instruction, bus.out_pc_plus4,
                     bus.imem_address, bus.halted, bus.fault, bus.fetch_count,
                     v.exp_valid, v.exp_pc, v.exp_instr, v.exp_plus4, v.exp_addr,
                     v.exp_halted, v.exp_fault, v.exp_count, v.chk_data);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        applyStimulus(v);
        checkOutput(v, name);
    endtask

    vec_t vecs[16];

    initial begin
        rst                 = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.out_ready       = 1'b0;

        //              rst rdv tgt       rdy ev cd pc        addr      h  f  cnt
        vecs[0]  = mk(1, 0, 32'h0,  1, 0, 1, 32'h0,  32'h0,  0, 0, 16'd0);
        vecs[1]  = mk(0, 0, 32'h0,  1, 0, 0, 32'h0,  32'h0,  0, 0, 16'd0);
        vecs[2]  = mk(0, 0, 32'h0,  1, 1, 1, 32'h0,  32'h4,  0, 0, 16'd0);
        vecs[3]  = mk(0, 0, 32'h0,  1, 1, 1, 32'h4,  32'h8,  0, 0, 16'd1);
        vecs[4]  = mk(0, 0, 32'h0,  1, 1, 1, 32'h8,  32'hC,  0, 0, 16'd2);
        vecs[5]  = mk(0, 0, 32'h0,  0, 1, 1, 32'h8,  32'hC,  0, 0, 16'd2);
        vecs[6]  = mk(0, 0, 32'h0,  0, 1, 1, 32'h8,  32'hC,  0, 0, 16'd2);
        vecs[7]  = mk(0, 0, 32'h0,  0, 1, 1, 32'h8,  32'hC,  0, 0, 16'd2);
        vecs[8]  = mk(0, 1, 32'h40, 0, 0, 0, 32'h0,  32'h40, 0, 0, 16'd2);
        vecs[9]  = mk(0, 0, 32'h0,  0, 1, 1, 32'h40, 32'h44, 0, 0, 16'd2);
        vecs[10] = mk(0, 0, 32'h0,  1, 1, 1, 32'h44, 32'h48, 0, 0, 16'd3);
        vecs[11] = mk(0, 1, 32'h10, 1, 0, 0, 32'h0,  32'h10, 0, 0, 16'd4);
        vecs[12] = mk(0, 0, 32'h0,  1, 1, 1, 32'h10, 32'h14, 0, 0, 16'd4);
        vecs[13] = mk(1, 1, 32'h80, 1, 0, 1, 32'h0,  32'h0,  0, 0, 16'd0);
        vecs[14] = mk(0, 0, 32'h0,  1, 0, 0, 32'h0,  32'h0,  0, 0, 16'd0);
        vecs[15] = mk(0, 0, 32'h0,  1, 1, 1, 32'h0,  32'h4,  0, 0, 16'd0);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i], $sformatf("table[%0d]", i));
        end

        // Stream the whole program with no stalls; the handshake count tracks the words consumed.
        for (int k = 1; k <= 102; k++) begin
            step(mk(0, 0, 32'h0, 1, 1, 1, 32'(4 * k), 32'(4 * k + 4), 0, 0, 16'(k)),
                 $sformatf("run_to_end[%0d]", k));
        end
        step(mk(0, 0, 32'h0,   1, 0, 0, 32'h0, 32'h19C, 1, 0, 16'd103), "halt_entry");
        step(mk(0, 0, 32'h0,   1, 0, 0, 32'h0, 32'h19C, 1, 0, 16'd103), "halt_hold");
        step(mk(0, 1, 32'h400, 1, 0, 0, 32'h0, 32'h19C, 1, 0, 16'd103), "halt_out_of_range_ignored");
        step(mk(0, 1, 32'h0,   1, 0, 0, 32'h0, 32'h0,   0, 0, 16'd103), "halt_restart_redirect");
        step(mk(0, 0, 32'h0,   1, 1, 1, 32'h0, 32'h4,   0, 0, 16'd103), "halt_restart_mem0");

        // Misaligned redirect: the flushed handshake still counts, then the state is terminal.
        step(mk(0, 1, 32'h42,  1, 0, 0, 32'h0, 32'h4, 0, 1, 16'd104), "fault_entry");
        step(mk(0, 1, 32'h0,   1, 0, 0, 32'h0, 32'h4, 0, 1, 16'd104), "fault_redirect_ignored");
        step(mk(0, 0, 32'h0,   1, 0, 0, 32'h0, 32'h4, 0, 1, 16'd104), "fault_sticky");
        step(mk(1, 0, 32'h0,   1, 0, 1, 32'h0, 32'h0, 0, 0, 16'd0),   "fault_cleared_by_reset");
        step(mk(0, 0, 32'h0,   1, 0, 0, 32'h0, 32'h0, 0, 0, 16'd0),   "post_fault_idle");
        step(mk(0, 0, 32'h0,   1, 1, 1, 32'h0, 32'h4, 0, 0, 16'd0),   "post_fault_mem0");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end
endmodule
